// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, frame format,
// oversampling ratio and the baud divider computation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // System clocks per oversample tick; integer truncation is intentional.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: free-running divider that emits a one-cycle
// tick every DIV clocks and can be re-phased by clr on a start edge.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int UART_INPUT_CLK = 100_000_000,
    parameter int baud_rate      = 9600,
    parameter int OVERSAMPLE     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV = calc_div(UART_INPUT_CLK, baud_rate, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt_q;

    // Divider counter: wraps at DIV-1, restarts from zero on reset or clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt_q <= '0;
        end else if (div_cnt_q == LAST) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    assign tick = (div_cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, two-flop input synchroniser and
// mid-bit sampling. Good frames update data_out with a done strobe; a zero
// stop bit raises a frame_err strobe instead.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_INPUT_CLK = 100_000_000,
    parameter int baud_rate      = 9600,
    parameter int OVERSAMPLE     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       done,
    output logic       busy,
    output logic       frame_err
);

    logic       s1_q, s2_q, s2_prev_q;
    state_t     state_q;
    logic [3:0] sample_cnt_q;
    logic [3:0] bit_idx_q;
    logic [7:0] shift_q;
    logic [7:0] data_out_q;
    logic       done_q, busy_q, frame_err_q;
    logic       tick;
    logic       start_clr_d;

    // Only a genuine high-to-low transition seen in IDLE starts a frame, so a
    // held-low line cannot retrigger and edges mid-frame are ignored.
    assign start_clr_d = (state_q == IDLE) && s2_prev_q && !s2_q;

    uart_rx_tick_gen #(
        .UART_INPUT_CLK (UART_INPUT_CLK),
        .baud_rate      (baud_rate),
        .OVERSAMPLE     (OVERSAMPLE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_clr_d),
        .tick (tick)
    );

    // Input synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s2_prev_q <= 1'b1;
        end else begin
            s1_q      <= rx;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
        end
    end

    // Receive FSM with registered busy/done/frame_err and output byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_clr_d) begin
                        state_q      <= START;
                        sample_cnt_q <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt_q == 4'd7) begin
                            sample_cnt_q <= '0;
                            if (!s2_q) begin
                                state_q   <= DATA;
                                bit_idx_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        sample_cnt_q <= sample_cnt_q + 4'd1;
                        if (sample_cnt_q == 4'd15) begin
                            shift_q   <= {s2_q, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 4'd1;
                            if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                                state_q <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        sample_cnt_q <= sample_cnt_q + 4'd1;
                        if (sample_cnt_q == 4'd15) begin
                            if (s2_q) begin
                                data_out_q <= shift_q;
                                done_q     <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, run at a reduced clock/baud ratio (DIV = 10,
// one bit = 160 clk) so each frame is short.
module tb_uart_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int DIV    = 10;
    localparam int BIT    = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       done, busy, frame_err;

    int checks = 0;
    int passed = 0;

    int done_cnt = 0, ferr_cnt = 0, done_wide = 0, both_cnt = 0, busy_cycles = 0;
    logic done_prev = 1'b0;

    uart_rx #(
        .UART_INPUT_CLK (CLK_HZ),
        .baud_rate      (BAUD),
        .OVERSAMPLE     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .done      (done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts pulses, over-long done pulses and overlaps.
    always @(posedge clk) begin
        if (done)               done_cnt    <= done_cnt + 1;
        if (done && done_prev)  done_wide   <= done_wide + 1;
        if (frame_err)          ferr_cnt    <= ferr_cnt + 1;
        if (done && frame_err)  both_cnt    <= both_cnt + 1;
        if (busy)               busy_cycles <= busy_cycles + 1;
        done_prev <= done;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int bclk);
        rx = 1'b0;
        idle(bclk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(bclk);
        end
        rx = stop_bit;
        idle(bclk);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        checks++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else passed++;
        checks++; if (done !== 1'b0)      $display("FAIL reset_done: got %b want 0", done); else passed++;
        checks++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
        rst = 1'b0;
        idle(BIT);
    endtask

    task automatic test_single;
        int d0, f0, w0, b0, busy_len;
        d0 = done_cnt; f0 = ferr_cnt; w0 = done_wide; b0 = busy_cycles;
        send_byte(8'hA5, 1'b1, BIT);
        idle(BIT);
        busy_len = busy_cycles - b0;
        checks++; if (data_out !== 8'hA5)     $display("FAIL single_data: got %h want a5", data_out); else passed++;
        checks++; if (done_cnt - d0 !== 1)    $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); else passed++;
        checks++; if (done_wide - w0 !== 0)   $display("FAIL single_done_width: got %0d wide cycles want 0", done_wide - w0); else passed++;
        checks++; if (ferr_cnt - f0 !== 0)    $display("FAIL single_frame_err: got %0d want 0", ferr_cnt - f0); else passed++;
        // 8 ticks to mid-start + 8*16 data ticks + 16 stop ticks = 152 ticks = 9.5 bits.
        checks++;
        if (busy_len < 152 * DIV - DIV || busy_len > 152 * DIV + DIV)
            $display("FAIL single_busy_len: got %0d want %0d +/- %0d", busy_len, 152 * DIV, DIV);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_byte(8'h3C, 1'b1, BIT);
        checks++; if (data_out !== 8'h3C) $display("FAIL b2b_first_data: got %h want 3c", data_out); else passed++;
        send_byte(8'hC3, 1'b1, BIT);
        idle(BIT);
        checks++; if (data_out !== 8'hC3)  $display("FAIL b2b_second_data: got %h want c3", data_out); else passed++;
        checks++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); else passed++;
        checks++; if (ferr_cnt - f0 !== 0) $display("FAIL b2b_frame_err: got %0d want 0", ferr_cnt - f0); else passed++;
    endtask

    task automatic test_glitch;
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        idle(4 * DIV);
        rx = 1'b1;
        idle(BIT);
        checks++; if (busy !== 1'b0)       $display("FAIL glitch_busy: got %b want 0", busy); else passed++;
        checks++; if (done_cnt - d0 !== 0) $display("FAIL glitch_done: got %0d want 0", done_cnt - d0); else passed++;
        checks++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_frame_err: got %0d want 0", ferr_cnt - f0); else passed++;
        send_byte(8'h55, 1'b1, BIT);
        idle(BIT);
        checks++; if (data_out !== 8'h55)  $display("FAIL glitch_next_data: got %h want 55", data_out); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL glitch_next_done: got %0d want 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_frame_err;
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_byte(8'hFF, 1'b0, BIT);
        idle(BIT);
        checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); else passed++;
        checks++; if (done_cnt - d0 !== 0) $display("FAIL ferr_done: got %0d want 0", done_cnt - d0); else passed++;
        checks++; if (data_out !== 8'h55)  $display("FAIL ferr_data_kept: got %h want 55", data_out); else passed++;
        checks++; if (busy !== 1'b0)       $display("FAIL ferr_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_rst_mid;
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        fork
            send_byte(8'h0F, 1'b1, BIT);
            begin
                // Middle of data bit 4: start bit + 4 data bits + half a bit.
                idle(5 * BIT + BIT / 2);
                checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", busy); else passed++;
                rst = 1'b1;
                idle(1);
                checks++; if (busy !== 1'b0)      $display("FAIL rst_mid_busy: got %b want 0", busy); else passed++;
                checks++; if (data_out !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", data_out); else passed++;
                checks++; if (done !== 1'b0)      $display("FAIL rst_mid_done: got %b want 0", done); else passed++;
                checks++; if (frame_err !== 1'b0) $display("FAIL rst_mid_ferr: got %b want 0", frame_err); else passed++;
            end
        join
        idle(BIT);
        rst = 1'b0;
        idle(BIT);
        checks++; if (done_cnt - d0 !== 0) $display("FAIL rst_mid_no_done: got %0d want 0", done_cnt - d0); else passed++;
        checks++; if (ferr_cnt - f0 !== 0) $display("FAIL rst_mid_no_ferr: got %0d want 0", ferr_cnt - f0); else passed++;
        send_byte(8'h81, 1'b1, BIT);
        idle(BIT);
        checks++; if (data_out !== 8'h81)  $display("FAIL rst_next_data: got %h want 81", data_out); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL rst_next_done: got %0d want 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_skew;
        int d0;
        d0 = done_cnt;
        send_byte(8'h5A, 1'b1, (BIT * 103) / 100);
        idle(BIT);
        checks++; if (data_out !== 8'h5A)  $display("FAIL skew_slow_data: got %h want 5a", data_out); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL skew_slow_done: got %0d want 1", done_cnt - d0); else passed++;
        send_byte(8'hA5, 1'b1, BIT);
        idle(BIT);
        send_byte(8'h5A, 1'b1, (BIT * 97) / 100);
        idle(BIT);
        checks++; if (data_out !== 8'h5A)  $display("FAIL skew_fast_data: got %h want 5a", data_out); else passed++;
        checks++; if (done_cnt - d0 !== 3) $display("FAIL skew_fast_done: got %0d want 3", done_cnt - d0); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_rst_mid;
        test_skew;
        checks++; if (both_cnt !== 0)  $display("FAIL done_ferr_overlap: got %0d want 0", both_cnt); else passed++;
        checks++; if (done_wide !== 0) $display("FAIL done_pulse_width: got %0d wide cycles want 0", done_wide); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
